pe_req_capture: RTL and testbench
=================================

Name: pe_req_capture

Overview:
- Request-capture stage directly upstream of the 4-input priority encoder.
- Synchronises raw asynchronous request lines, detects rising edges and holds each request as a sticky pending bit. Presents the masked pending vector, which drives the encoder input, with a valid/ready handshake.
- Clears a pending bit when the consumer returns the encoded index as an acknowledge.

Parameters:
- N, 4, number of request lines; must match the encoder input width.
- SYNC_STAGES, 2, synchroniser depth per line; legal range 1..3.
- IW, $clog2(N), index width; derived, not overridable; 2 at default.

Ports:
- clk  input  1  single clock; all flops rise-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  N  raw asynchronous request lines.
- mask  input  N  synchronous; 1 hides that line from pend_out but does not stop capture.
- pend_out  output  N  registered (pending & ~mask); drives encoder in.
- pend_valid  output  1  pend_out holds at least one request and the block is waiting for an ack.
- ack_valid  input  1  consumer acknowledge strobe.
- ack_idx  input  IW  index being acknowledged; normally the encoder output.
- ack_ready  output  1  block accepts an ack this cycle.
- ack_err  output  1  one-cycle pulse for an accepted ack whose index is not set in pend_out.

Behaviour:
- Reset (async assert, sync release): sync flops, edge-history flops, pending = 0; FSM = IDLE; pend_out = 0, pend_valid = 0, ack_ready = 0, ack_err = 0.
- Synchroniser:
  - SYNC_STAGES flops per line, then an edge-history flop.
  - edge[i] = sync[i] & ~hist[i].
  - A line held high through reset release produces exactly one edge after reset.
- Pending update, per bit, each clock:
  - Set if edge[i].
  - Else clear if an ack is accepted with ack_idx == i.
  - Else hold.
  - Set beats clear in the same cycle: the new edge is a new request.
  - Mask does not affect capture.
- Latency: req_in rising before edge k gives pending[i] set at edge k+SYNC_STAGES, and pend_valid at edge k+SYNC_STAGES+1.
- pend_out is a registered copy of pending & ~mask, updated every clock. Mask changes appear one cycle later.
- FSM states are IDLE, ASSERT and RECOVER:
  - IDLE: pend_valid = 0, ack_ready = 0. Go to ASSERT when |pend_out.
  - ASSERT: pend_valid = 1, ack_ready = 1.
    - Ack accepted (ack_valid & ack_ready): go to RECOVER.
    - Else if pend_out == 0 (all masked or cleared): go to IDLE.
    - pend_out may change while in ASSERT; the consumer must re-sample it each cycle.
  - RECOVER: one-cycle bubble. pend_valid = 0, ack_ready = 0, so the encoder sees the cleared vector before the next ack. Go to ASSERT if |pend_out, else IDLE.
- Acks and errors:
  - ack_valid outside ASSERT is ignored: no clear, no ack_err.
  - An accepted ack with pend_out[ack_idx] == 0 leaves pending unchanged and still moves the FSM to RECOVER. ack_err pulses high the next cycle.
- Index wrap: ack_idx >= N (non-power-of-2 N only) is treated as not set, so ack_err pulses.
- Reset mid-operation discards all pending requests; no partial state survives.

Optional Feature:
- Macro: PE_REQ_OVERRUN_EN.
- Defined:
  - Adds output overrun (N, sticky) and input clr_overrun (1).
  - overrun[i] is set when edge[i] occurs while pending[i] == 1 and bit i is not being cleared that cycle.
  - clr_overrun = 1 clears all bits; a simultaneous set wins.
  - overrun resets to 0.
- Not defined: both ports absent; repeated edges on a pending line are silently merged.

Test Plan:
- Reset, then raise req_in = 4'b0100 one cycle before edge k (SYNC_STAGES = 2) -> pending[2] at edge k+2, pend_out = 4'b0100, pend_valid = 1 at k+3, ack_ready = 1.
- Pending 4'b1010, ack_idx = 3 accepted -> next cycle pend_out = 4'b0010 and RECOVER (pend_valid = 0 for one cycle), then ASSERT; ack_idx = 1 accepted -> pend_out = 4'b0000, FSM ends in IDLE.
- Pending 4'b0001, mask = 4'b0001 -> pend_out = 0, FSM returns to IDLE; clear mask -> pend_out = 4'b0001, pend_valid reasserts with pending still held.
- In ASSERT with pend_out = 4'b0100, ack_idx = 0 -> ack_err high for exactly one cycle, pend_out still 4'b0100 after RECOVER.
- New edge on line 1 in the same cycle as ack_idx = 1 accepted -> pending[1] remains 1; with PE_REQ_OVERRUN_EN, overrun[1] = 0; a second edge without ack sets overrun[1] = 1 until clr_overrun.
- Assert rst_n low while in ASSERT with pending 4'b1111 -> all outputs 0 immediately (async); after release with req_in = 4'b0000, pend_valid stays 0.

Source files
------------

// File: rtl/pe_req_capture_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pe_req_capture_if                                               |
// | Brief    : Request/ack bundle between pe_req_capture and its consumer.     |
// |            Optional overrun ports appear when PE_REQ_OVERRUN_EN is defined.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface pe_req_capture_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req_in;
    logic [N-1:0]  mask;
    logic [N-1:0]  pend_out;
    logic          pend_valid;
    logic          ack_valid;
    logic [IW-1:0] ack_idx;
    logic          ack_ready;
    logic          ack_err;
`ifdef PE_REQ_OVERRUN_EN
    logic [N-1:0]  overrun;
    logic          clr_overrun;

    modport slave (
        input  req_in, mask, ack_valid, ack_idx, clr_overrun,
        output pend_out, pend_valid, ack_ready, ack_err, overrun
    );
    modport master (
        output req_in, mask, ack_valid, ack_idx, clr_overrun,
        input  pend_out, pend_valid, ack_ready, ack_err, overrun
    );
`else
    modport slave (
        input  req_in, mask, ack_valid, ack_idx,
        output pend_out, pend_valid, ack_ready, ack_err
    );
    modport master (
        output req_in, mask, ack_valid, ack_idx,
        input  pend_out, pend_valid, ack_ready, ack_err
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pe_req_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pe_req_capture                                                  |
// | Brief    : Synchronises async request lines, captures rising edges as      |
// |            sticky pending bits and offers them to a priority encoder with  |
// |            a valid/ack handshake. Optional macro: PE_REQ_OVERRUN_EN.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module pe_req_capture #(
    parameter  int N           = 4,
    parameter  int SYNC_STAGES = 2,   // legal 1..3
    localparam int IW          = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pe_req_capture_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    logic [N-1:0] sync_q [SYNC_STAGES];
    logic [N-1:0] hist_q;
    logic [N-1:0] pend_q,     pend_d;
    logic [N-1:0] pend_out_q, pend_out_d;
    logic         ack_err_q,  ack_err_d;
    state_t       state_q,    state_d;

    logic [N-1:0] edge_w;
    logic [N-1:0] clr_vec_w;
    logic         ack_acc_w;
    logic         ack_hit_w;
    logic         idx_ok_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= bus.req_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // hist resets low, so a line held high across reset yields one edge.
    assign edge_w    = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign ack_acc_w = bus.ack_valid && (state_q == ST_ASSERT);
    assign idx_ok_w  = (int'(bus.ack_idx) < N);
    assign ack_hit_w = ack_acc_w && idx_ok_w && pend_out_q[bus.ack_idx];

    always_comb begin
        clr_vec_w = '0;
        for (int i = 0; i < N; i++) begin
            clr_vec_w[i] = ack_hit_w && (int'(bus.ack_idx) == i);
        end
        // A fresh edge is a new request, so set overrides a same-cycle clear.
        pend_d     = (pend_q & ~clr_vec_w) | edge_w;
        pend_out_d = pend_d & ~bus.mask;
        ack_err_d  = ack_acc_w && !ack_hit_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            pend_out_q <= '0;
            ack_err_q  <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            pend_q     <= pend_d;
            pend_out_q <= pend_out_d;
            ack_err_q  <= ack_err_d;
            state_q    <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|pend_out_q) state_d = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (ack_acc_w)         state_d = ST_RECOVER;
                else if (~|pend_out_q) state_d = ST_IDLE;
            end
            // Bubble lets the encoder settle on the cleared vector.
            ST_RECOVER: begin
                state_d = (|pend_out_q) ? ST_ASSERT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.pend_out   = pend_out_q;
    assign bus.pend_valid = (state_q == ST_ASSERT);
    assign bus.ack_ready  = (state_q == ST_ASSERT);
    assign bus.ack_err    = ack_err_q;

`ifdef PE_REQ_OVERRUN_EN
    logic [N-1:0] overrun_q, overrun_d;

    always_comb begin
        overrun_d = bus.clr_overrun ? '0 : overrun_q;
        overrun_d = overrun_d | (edge_w & pend_q & ~clr_vec_w);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overrun_q <= '0;
        else        overrun_q <= overrun_d;
    end

    assign bus.overrun = overrun_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_req_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pe_req_capture                                               |
// | Brief    : Directed scoreboard bench for pe_req_capture (N=4, 2 stages).   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_pe_req_capture;

    logic clk;
    logic rst_n;

    pe_req_capture_if #(.N(4)) bus ();

    pe_req_capture #(.N(4), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // {pend_valid, ack_ready, ack_err, 0, pend_out}
    function automatic logic [7:0] status();
        return {bus.pend_valid, bus.ack_ready, bus.ack_err, 1'b0, bus.pend_out};
    endfunction

    task automatic push(input string tag, input logic [3:0] p,
                        input logic pv, input logic ar, input logic ae);
        exp_t e;
        e.tag = tag;
        e.exp = {pv, ar, ae, 1'b0, p};
        sb.push_back(e);
    endtask

    task automatic cmp_next();
        exp_t       e;
        logic [7:0] obs;
        obs = status();
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%02h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%02h expected=%02h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cmp_next();
    endtask

`ifdef PE_REQ_OVERRUN_EN
    task automatic chk_ovr(input string tag, input logic [3:0] exp);
        checks++;
        assert (bus.overrun === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, bus.overrun, exp);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_in    = '0;
        bus.mask      = '0;
        bus.ack_valid = 1'b0;
        bus.ack_idx   = '0;
`ifdef PE_REQ_OVERRUN_EN
        bus.clr_overrun = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        push("reset", 4'h0, 0, 0, 0);
        cmp_next();

        // Capture latency: req raised before edge k, pending at k+2, valid at k+3
        rst_n      = 1'b1;
        bus.req_in = 4'b0100;
        push("t1_k",   4'h0, 0, 0, 0);
        push("t1_k1",  4'h0, 0, 0, 0);
        push("t1_k2",  4'h4, 0, 0, 0);
        push("t1_k3",  4'h4, 1, 1, 0);
        repeat (4) step();
        bus.ack_valid = 1'b1; bus.ack_idx = 2'd2;
        push("t1_ack", 4'h0, 0, 0, 0);
        step();
        bus.ack_valid = 1'b0;
        push("t1_idle", 4'h0, 0, 0, 0);
        step();

        // Two pending, acked one at a time through RECOVER
        bus.req_in = 4'b1010;
        push("t2_k",  4'h0, 0, 0, 0);
        push("t2_k1", 4'h0, 0, 0, 0);
        push("t2_k2", 4'hA, 0, 0, 0);
        push("t2_k3", 4'hA, 1, 1, 0);
        repeat (4) step();
        bus.ack_valid = 1'b1; bus.ack_idx = 2'd3;
        push("t2_ack3", 4'h2, 0, 0, 0);
        step();
        bus.ack_valid = 1'b0;
        push("t2_reassert", 4'h2, 1, 1, 0);
        step();
        bus.ack_valid = 1'b1; bus.ack_idx = 2'd1;
        push("t2_ack1", 4'h0, 0, 0, 0);
        step();
        bus.ack_valid = 1'b0;
        push("t2_idle",  4'h0, 0, 0, 0);
        push("t2_idle2", 4'h0, 0, 0, 0);
        repeat (2) step();

        // Mask hides but keeps the request; ack outside ASSERT is ignored
        bus.req_in = 4'b0001;
        push("t3_k",  4'h0, 0, 0, 0);
        push("t3_k1", 4'h0, 0, 0, 0);
        push("t3_k2", 4'h1, 0, 0, 0);
        push("t3_k3", 4'h1, 1, 1, 0);
        repeat (4) step();
        bus.mask = 4'b0001;
        push("t3_masked", 4'h0, 1, 1, 0);
        push("t3_idle",   4'h0, 0, 0, 0);
        repeat (2) step();
        bus.ack_valid = 1'b1; bus.ack_idx = 2'd0;
        push("t3_ign_ack", 4'h0, 0, 0, 0);
        step();
        bus.ack_valid = 1'b0;
        bus.mask      = 4'b0000;
        push("t3_unmask",   4'h1, 0, 0, 0);
        push("t3_reassert", 4'h1, 1, 1, 0);
        repeat (2) step();
        bus.ack_valid = 1'b1; bus.ack_idx = 2'd0;
        push("t3_ack0", 4'h0, 0, 0, 0);
        step();
        bus.ack_valid = 1'b0;
        push("t3_idle2", 4'h0, 0, 0, 0);
        step();

        // Ack of an index that is not pending
        bus.req_in = 4'b0100;
        push("t4_k",  4'h0, 0, 0, 0);
        push("t4_k1", 4'h0, 0, 0, 0);
        push("t4_k2", 4'h4, 0, 0, 0);
        push("t4_k3", 4'h4, 1, 1, 0);
        repeat (4) step();
        bus.ack_valid = 1'b1; bus.ack_idx = 2'd0;
        push("t4_err", 4'h4, 0, 0, 1);
        step();
        bus.ack_valid = 1'b0;
        push("t4_err_end", 4'h4, 1, 1, 0);
        step();
        bus.ack_valid = 1'b1; bus.ack_idx = 2'd2;
        push("t4_ack2", 4'h0, 0, 0, 0);
        step();
        bus.ack_valid = 1'b0;
        push("t4_idle", 4'h0, 0, 0, 0);
        step();

        // New edge in the same cycle as the ack of that line
        bus.req_in = 4'b0010;
        push("t5_k",  4'h0, 0, 0, 0);
        push("t5_k1", 4'h0, 0, 0, 0);
        push("t5_k2", 4'h2, 0, 0, 0);
        push("t5_k3", 4'h2, 1, 1, 0);
        repeat (4) step();
        bus.req_in = 4'b0000;
        push("t5_lo1", 4'h2, 1, 1, 0);
        push("t5_lo2", 4'h2, 1, 1, 0);
        repeat (2) step();
        bus.req_in = 4'b0010;
        push("t5_hi1", 4'h2, 1, 1, 0);
        push("t5_hi2", 4'h2, 1, 1, 0);
        repeat (2) step();
        bus.ack_valid = 1'b1; bus.ack_idx = 2'd1;
        push("t5_set_wins", 4'h2, 0, 0, 0);
        step();
        bus.ack_valid = 1'b0;
`ifdef PE_REQ_OVERRUN_EN
        chk_ovr("t5_ovr_none", 4'b0000);
`endif
        push("t5_reassert", 4'h2, 1, 1, 0);
        step();
        // Second edge with no ack in between
        bus.req_in = 4'b0000;
        push("t5_lo3", 4'h2, 1, 1, 0);
        push("t5_lo4", 4'h2, 1, 1, 0);
        repeat (2) step();
        bus.req_in = 4'b0010;
        push("t5_hi3", 4'h2, 1, 1, 0);
        push("t5_hi4", 4'h2, 1, 1, 0);
        push("t5_edge2", 4'h2, 1, 1, 0);
        repeat (3) step();
`ifdef PE_REQ_OVERRUN_EN
        chk_ovr("t5_ovr_set", 4'b0010);
        push("t5_hold", 4'h2, 1, 1, 0);
        step();
        chk_ovr("t5_ovr_sticky", 4'b0010);
        bus.clr_overrun = 1'b1;
        push("t5_clr", 4'h2, 1, 1, 0);
        step();
        bus.clr_overrun = 1'b0;
        chk_ovr("t5_ovr_clr", 4'b0000);
`endif
        bus.ack_valid = 1'b1; bus.ack_idx = 2'd1;
        push("t5_ack1", 4'h0, 0, 0, 0);
        step();
        bus.ack_valid = 1'b0;
        push("t5_idle", 4'h0, 0, 0, 0);
        step();

        // Async reset in the middle of ASSERT with all lines pending
        bus.req_in = 4'b0000;
        push("t6_lo1", 4'h0, 0, 0, 0);
        push("t6_lo2", 4'h0, 0, 0, 0);
        push("t6_lo3", 4'h0, 0, 0, 0);
        repeat (3) step();
        bus.req_in = 4'b1111;
        push("t6_k",  4'h0, 0, 0, 0);
        push("t6_k1", 4'h0, 0, 0, 0);
        push("t6_k2", 4'hF, 0, 0, 0);
        push("t6_k3", 4'hF, 1, 1, 0);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        push("t6_async_rst", 4'h0, 0, 0, 0);
        cmp_next();
`ifdef PE_REQ_OVERRUN_EN
        chk_ovr("t6_ovr_rst", 4'b0000);
`endif
        bus.req_in = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push("t6_post1", 4'h0, 0, 0, 0);
        push("t6_post2", 4'h0, 0, 0, 0);
        push("t6_post3", 4'h0, 0, 0, 0);
        push("t6_post4", 4'h0, 0, 0, 0);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
